// File: rtl/pipe_pkg.sv
// Shared pipeline-stage field layouts and the bubble control value.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [6:0]  brc_input;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } datapath_t;

    typedef struct packed {
        logic       reg_wr;
        logic [2:0] br_type;
        logic       sel_a;
        logic       sel_b;
        logic [3:0] alu_op;
        logic       mem_wr;
        logic       mem_rd;
        logic [2:0] mem_mask;
        logic [1:0] set_wb;
    } control_t;

    localparam int PIPE_DATA_W = $bits(datapath_t);
    localparam int PIPE_CTRL_W = $bits(control_t);

    localparam control_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_elastic_buf.sv
// Circular DEPTH-entry buffer for an elastic pipeline stage: storage, pointers, count.
module pipe_elastic_buf
    import pipe_pkg::*;
#(
    parameter  int DATA_W   = PIPE_DATA_W,
    parameter  int CTRL_W   = PIPE_CTRL_W,
    parameter  int DEPTH    = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [CTRL_W-1:0]   wr_ctrl,
    output logic [DATA_W-1:0]   rd_data,
    output logic [CTRL_W-1:0]   rd_ctrl,
    output logic [CNT_BITS-1:0] count
);

    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [CTRL_W-1:0]   mem_ctrl_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap for free.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_BITS'(1);
            else if (pop && !push) count_d = count_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_ctrl_q[i] <= '0;
            end
        end else if (push && !clr) begin
            mem_data_q[wr_ptr_q] <= wr_data;
            mem_ctrl_q[wr_ptr_q] <= wr_ctrl;
        end
    end

    assign rd_data = mem_data_q[rd_ptr_q];
    assign rd_ctrl = mem_ctrl_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with stall/flush gating and bubble-masked control.
// Define PIPE_PERF_EN to build the saturating stall_cycles / flush_count counters.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter  int DATA_W = PIPE_DATA_W,
    parameter  int CTRL_W = PIPE_CTRL_W,
    parameter  int DEPTH  = 2,
    parameter  int CNT_W  = 32,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    logic [OCC_W-1:0]  count;
    logic [CTRL_W-1:0] head_ctrl;
    logic              push, pop;

    // in_ready deliberately ignores out_ready: a full stage never fills on a same-cycle pop.
    assign in_ready  = reset_n & (count < OCC_W'(DEPTH)) & ~stall & ~flush;
    assign out_valid = (count != '0) & ~stall & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    pipe_elastic_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .wr_ctrl (in_ctrl),
        .rd_data (out_data),
        .rd_ctrl (head_ctrl),
        .count   (count)
    );

    // A bubble must never carry reg_wr or mem_wr downstream.
    assign out_ctrl  = out_valid ? head_ctrl : CTRL_W'(CTRL_BUBBLE);
    assign occupancy = count;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            if (flush && (flush_count_q != '1))  flush_count_q  <= flush_count_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline-stage register. Successor to the fixed ID/EX register.
- Carries a data field and a control field per instruction, with a valid/ready handshake, a DEPTH-entry buffer, and stall/flush controls.
- Control is forced to zero on bubbles.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage widths.

Parameters:
- DATA_W, 172, width of datapath field (rs1, rs2, imm, brc_input, PC, PC4, rd).
- CTRL_W, 17, width of control field (reg_wr, br_type, sel_a, sel_b, alu_op, mem_wr, mem_rd, mem_mask, set_wb).
- DEPTH, 2, buffer entries; power of two, >= 2.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold stage: no accept, no issue
- flush  in  1  discard all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_data  in  DATA_W  upstream datapath field
- in_ctrl  in  CTRL_W  upstream control field
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  DATA_W  head datapath field
- out_ctrl  out  CTRL_W  head control field; zero when out_valid=0
- occupancy  out  $clog2(DEPTH+1)  entries held
- stall_cycles  out  CNT_W  cycles with stall=1 (see optional feature)
- flush_count  out  CNT_W  flush events (see optional feature)

Behaviour:
- Reset (reset_n=0, asynchronous): the following clear immediately:
  - count, rd_ptr, wr_ptr, all storage entries;
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=0 while asserted;
  - occupancy=0;
  - counters=0.
  - Reset mid-transfer drops all entries, with no partial push.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~stall & ~flush. There is no combinational path from out_ready, so a full buffer refuses input even on a same-cycle pop.
- out_valid = (count != 0) & ~stall & ~flush.
- out_data = mem[rd_ptr] at all times.
- out_ctrl = out_valid ? mem_ctrl[rd_ptr] : 0. Bubbles must never carry reg_wr or mem_wr.
- Latency: an entry pushed at edge N is visible on out_* after edge N. Minimum 1 cycle, no fall-through.
- Throughput: 1 entry/cycle while 0 < count < DEPTH and both sides are active.
- Per edge, priority order:
  1. flush: count=0, rd_ptr=wr_ptr=0; input that cycle is discarded.
  2. stall: all state held.
  3. otherwise: push writes mem[wr_ptr] and increments wr_ptr; pop increments rd_ptr; count += push - pop.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count never exceeds DEPTH and never underflows.
- flush and stall both high: flush wins.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - stall_cycles increments every edge with stall=1 and reset_n=1.
  - flush_count increments every edge with flush=1.
  - Both saturate at all-ones and are cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg:
  - datapath_t and control_t packed structs;
  - localparams PIPE_DATA_W=$bits(datapath_t) and PIPE_CTRL_W=$bits(control_t);
  - bubble constant CTRL_BUBBLE='0.
- Sub-module pipe_elastic_buf: storage array plus pointer/count logic.
- Top level adds the stall/flush gating, bubble masking and perf counters.

Test Plan:
1. Reset then single push of in_data=0xA5..., in_ctrl=0x1FFFF with out_ready=1 -> out_valid=1 exactly one cycle later with matching fields; occupancy 1 then 0.
2. out_ready=0, push 3 entries at DEPTH=2 -> in_ready=0 after the 2nd push, 3rd entry not accepted; out_ready=1 -> outputs entries 1 and 2 in order.
3. Stall during streaming (stall=1 for 4 cycles) -> out_valid=0, out_ctrl=0, in_ready=0, state unchanged; resumes with the next in-order entry. With PIPE_PERF_EN, stall_cycles=4.
4. flush with occupancy=2 plus a simultaneous in_valid -> next cycle occupancy=0, out_valid=0, and the flushed-cycle input is absent. flush+stall together -> flush wins. flush_count=1.
5. Continuous push/pop for 8 cycles at DEPTH=4 -> pointer wrap, 1 entry/cycle, outputs match inputs in order.
6. reset_n asserted mid-stream with occupancy=1 -> outputs zero immediately; after release the first new push appears with nothing stale.
